// File: rtl/dti_apb_master_arbiter.sv
// dti_apb_master_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters
module dti_apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d, idx, pick;
  logic [WW-1:0]       wd_q, wd_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                found, grant, tmo, done;

  // first pending requester at or above the pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // next state, latched transfer, watchdog and response capture
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    wd_d        = wd_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    grant       = (state_q == IDLE) && found;
    tmo         = (state_q == ACCESS) && !PREADY && (wd_q == WW'(TIMEOUT - 1));
    done        = (state_q == ACCESS) && (PREADY || tmo);
    if (grant) begin
      state_d = SETUP;
      gnt_d   = pick;
      ptr_d   = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pick == IW'(i)) begin
          paddr_d  = req_addr[i*ADDR_W +: ADDR_W];
          pwrite_d = req_write[i];
          pwdata_d = req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
    if (state_q == SETUP) state_d = ACCESS;
    if (state_q == ACCESS) begin
      wd_d = done ? '0 : (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
      if (done) begin
        state_d     = IDLE;
        rsp_valid_d = NUM_REQ'(1) << gnt_q;
        rdata_d     = (PREADY && !pwrite_q) ? PRDATA : '0;
        err_d       = PREADY ? PSLVERR : 1'b1;
      end
    end
  end

  // state and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      wd_q        <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      wd_q        <= wd_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // acceptance is suppressed while reset is held so every output reads 0
  assign req_ready = (PRESETn && grant) ? (NUM_REQ'(1) << pick) : '0;
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: doc/dti_apb_master_arbiter.md
Name: dti_apb_master_arbiter

Overview:
Shares a single APB master port between NUM_REQ local requesters using round-robin arbitration. It sequences the APB SETUP/ACCESS phases, waits on PREADY and returns read data and error status to the granted requester. A watchdog terminates stalled transfers. The APB-side outputs connect directly to the master-side signal group of the APB interface bundle.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, PADDR width
DATA_W, 32, PWDATA/PRDATA width
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before forced termination (>=2)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester; held until req_ready
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_ready  out  NUM_REQ  one-hot acceptance pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_W  read data; valid with rsp_valid, shared
rsp_err  out  1  PSLVERR or timeout; valid with rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Clock and reset: single clock, PCLK. PRESETn is asynchronous and active-low.
- Reset values: all outputs 0; state=IDLE; round-robin pointer=0; watchdog=0.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is set, grant the first set bit searching upward from the pointer (wrapping). In the same cycle, pulse req_ready[g]=1 (combinational from the registered state and req_valid). Latch write, addr and wdata of requester g. Set pointer=(g+1) mod NUM_REQ. Next state is SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latched values. Next state is ACCESS, unconditionally.
- ACCESS: PSEL=1, PENABLE=1, same address and data.
  - If PREADY=1: capture PRDATA (forced to 0 on writes) and PSLVERR. Next cycle, rsp_valid[g]=1 for exactly one cycle. Next state is IDLE.
  - If PREADY=0: increment the watchdog. When the watchdog reaches TIMEOUT, abort: next cycle PSEL=PENABLE=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0. Next state is IDLE.
  - Watchdog clears on leaving ACCESS.
- APB output registers: PSEL, PENABLE, PADDR, PWRITE and PWDATA are registered. PADDR, PWRITE and PWDATA hold their last values in IDLE. PSEL=0 in IDLE.
- Response pulse and new grant: the rsp_valid pulse cycle coincides with IDLE, so a new grant may occur in that same cycle. A back-to-back transfer therefore takes 3 cycles per transfer plus wait states.
- rsp_rdata and rsp_err hold their values until the next completion.
- req_valid drop: deasserting req_valid before req_ready is permitted and withdraws the request. Deasserting after grant has no effect.
- Only one transfer is outstanding at a time. req_ready and rsp_valid are never asserted to two requesters at once.
- Reset asserted mid-transfer: immediately return to the reset values. No rsp_valid is issued for the aborted transfer.
- Out-of-state inputs: PREADY and PSLVERR are ignored outside ACCESS.
- Watchdog width: clog2(TIMEOUT+1) bits. No wrap; it saturates at TIMEOUT.

Test Plan:
1. Single write: req 0 writes addr 0x10, data 0xA5A5A5A5, PREADY=1 tied. Required: req_ready[0] in cycle N; SETUP at N+1; ACCESS at N+2; rsp_valid[0] at N+3 with rsp_err=0.
2. Read with wait states: req 1 reads 0x24 while the slave holds PREADY low for 3 ACCESS cycles, then returns PRDATA=0x12345678. Required: PENABLE high for 4 cycles; rsp_rdata=0x12345678; rsp_valid[1] 1 cycle after PREADY.
3. Round robin: both requesters hold valid continuously for 4 transfers. Required: grant order 0,1,0,1; no cycle has 2 bits set in req_ready or rsp_valid.
4. Slave error: PSLVERR=1 with PREADY on a write. Required: rsp_err=1 and rsp_rdata=0 on the rsp_valid cycle; the next transfer proceeds normally.
5. Timeout: PREADY stuck low with TIMEOUT=16. Required: after 16 ACCESS cycles, PSEL drops; rsp_valid pulses with rsp_err=1 and rdata=0; FSM returns to IDLE and accepts the next request.
6. Reset mid-ACCESS: assert PRESETn=0 asynchronously during a wait state. Required: all outputs go to 0 immediately; no rsp_valid is issued; the first post-reset grant goes to requester 0.
